// File: rtl/inst_fetch_bridge.sv
// Fetch bridge: turns the per-cycle IF PC into single-outstanding sram-like
// instruction bus transactions and stalls the pipeline until the word is ready.
module inst_fetch_bridge #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_stall,
  input  logic        if_cancel,
  output logic [31:0] if_instr,
  output logic        stallreq_from_if,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_DONE,
    S_DISCARD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_buf_q, instr_buf_d;
  logic        pc_aligned;

  assign pc_aligned = (if_pc[1:0] == 2'b00);

  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      instr_buf_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      instr_buf_q <= instr_buf_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    instr_buf_d      = instr_buf_q;
    inst_req         = 1'b0;
    inst_addr        = '0;
    stallreq_from_if = 1'b1;
    if_instr         = NOP_INSTR;

    unique case (state_q)
      S_IDLE: begin
        if (!pc_aligned) begin
          // Misaligned PC bypasses the bus; the datapath raises AdEL itself.
          instr_buf_d = NOP_INSTR;
          state_d     = S_DONE;
        end else begin
          inst_req  = 1'b1;
          inst_addr = if_pc;
          if (inst_addr_ok) begin
            state_d = if_cancel ? S_DISCARD : S_WAIT_DATA;
          end
        end
      end

      S_WAIT_DATA: begin
        if (inst_data_ok) begin
          if (if_cancel) begin
            state_d = S_IDLE;
          end else begin
            instr_buf_d = inst_rdata;
            state_d     = S_DONE;
          end
        end else if (if_cancel) begin
          state_d = S_DISCARD;
        end
      end

      S_DISCARD: begin
        if (inst_data_ok) begin
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        stallreq_from_if = 1'b0;
        if_instr         = instr_buf_q;
        if (if_cancel || !if_stall) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are forced quiet during the reset cycle, not just after it.
    if (rst) begin
      inst_req         = 1'b0;
      inst_addr        = '0;
      stallreq_from_if = 1'b0;
      if_instr         = NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Randomized bench for inst_fetch_bridge: a datapath/bus-slave driver feeds PCs,
// stalls and cancels; a monitor checks against a transaction-level model.
module tb_inst_fetch_bridge;

  localparam logic [31:0] NOP    = 32'hFFFF_0001;
  localparam int unsigned NCYC   = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_stall;
  logic        if_cancel;
  logic [31:0] if_instr;
  logic        stallreq_from_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q[$];

  inst_fetch_bridge #(.NOP_INSTR(NOP)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .if_stall         (if_stall),
    .if_cancel        (if_cancel),
    .if_instr         (if_instr),
    .stallreq_from_if (stallreq_from_if),
    .inst_req         (inst_req),
    .inst_wr          (inst_wr),
    .inst_size        (inst_size),
    .inst_addr        (inst_addr),
    .inst_wdata       (inst_wdata),
    .inst_addr_ok     (inst_addr_ok),
    .inst_data_ok     (inst_data_ok),
    .inst_rdata       (inst_rdata)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as seen by the bus slave.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] expect_for(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) ? NOP : mem_word(pc);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: datapath stimulus plus a random-latency bus slave.
  initial begin
    logic [31:0] pc;
    logic [31:0] t;
    logic [1:0]  lo;
    logic        busy;
    logic        advance;
    logic        was_cancel;
    int unsigned cnt;
    logic [31:0] saddr;

    rst          = 1'b1;
    pc           = 32'hBFC0_0000;
    if_pc        = pc;
    if_stall     = 1'b0;
    if_cancel    = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    busy         = 1'b0;
    advance      = 1'b0;
    was_cancel   = 1'b0;
    cnt          = 0;
    saddr        = '0;
    exp_q.push_back(expect_for(pc));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (advance) begin
        t  = $urandom();
        lo = 2'($urandom_range(1, 3));
        case ($urandom_range(0, 9))
          0:       pc = {t[31:2], lo};
          1, 2:    pc = {t[31:2], 2'b00};
          default: pc = was_cancel ? 32'hBFC0_0380 : {pc[31:2] + 30'd1, 2'b00};
        endcase
        if (was_cancel && pc[1:0] != 2'b00 && ($urandom_range(0, 1) == 0)) pc = 32'hBFC0_0380;
        if_pc = pc;
        exp_q.push_back(expect_for(pc));
      end

      if_stall  = (stallreq_from_if == 1'b0) && ($urandom_range(0, 2) == 0);
      if_cancel = !(pc[1:0] != 2'b00 && stallreq_from_if) && ($urandom_range(0, 11) == 0);

      inst_addr_ok = !busy && ($urandom_range(0, 1) == 1);
      inst_data_ok = busy && (cnt == 0);
      inst_rdata   = inst_data_ok ? mem_word(saddr) : $urandom();

      @(negedge clk);
      advance    = (stallreq_from_if == 1'b0 && !if_stall) || if_cancel;
      was_cancel = if_cancel;
      if (busy) begin
        if (inst_data_ok) busy = 1'b0;
        else if (cnt > 0) cnt--;
      end
      if (inst_req && inst_addr_ok) begin
        busy  = 1'b1;
        cnt   = $urandom_range(0, 3);
        saddr = inst_addr;
      end
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: transaction-level model of when the instruction must be ready.
  initial begin
    logic        exp_done;
    logic        m_out;
    logic        m_live;
    logic        nd;
    logic        exp_req;
    int unsigned since;

    exp_done = 1'b0;
    m_out    = 1'b0;
    m_live   = 1'b0;
    since    = 0;

    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_req", {31'd0, inst_req}, 32'd0);
        check("reset_stallreq", {31'd0, stallreq_from_if}, 32'd0);
        check("reset_instr", if_instr, NOP);
        exp_done = 1'b0;
        m_out    = 1'b0;
        m_live   = 1'b0;
        since    = 0;
      end else begin
        check("inst_wr", {31'd0, inst_wr}, 32'd0);
        check("inst_size", {30'd0, inst_size}, 32'd2);
        check("inst_wdata", inst_wdata, 32'd0);

        // A request is due only with nothing outstanding, nothing ready, aligned PC.
        exp_req = !exp_done && !m_out && (if_pc[1:0] == 2'b00);
        check("stallreq", {31'd0, stallreq_from_if}, {31'd0, !exp_done});
        check("inst_req", {31'd0, inst_req}, {31'd0, exp_req});
        if (exp_req) check("inst_addr", inst_addr, if_pc);

        if (exp_done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got instr %h expected none pending", if_instr);
          end else begin
            check("if_instr", if_instr, exp_q[0]);
          end
        end else begin
          check("if_instr_idle", if_instr, NOP);
        end

        nd = 1'b0;
        if (exp_done) nd = if_stall && !if_cancel;
        else if (!m_out && if_pc[1:0] != 2'b00) nd = 1'b1;
        else if (m_out && inst_data_ok && m_live && !if_cancel) nd = 1'b1;

        if ((exp_done && (!if_stall || if_cancel)) || (!exp_done && if_cancel)) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          since = 0;
        end else begin
          since++;
        end

        if (m_out && inst_data_ok) m_out = 1'b0;
        else if (m_out && if_cancel) m_live = 1'b0;
        if (exp_req && inst_addr_ok) begin
          m_out  = 1'b1;
          m_live = !if_cancel;
        end
        exp_done = nd;

        if (since > 60) begin
          checks++;
          errors++;
          $display("FAIL progress_timeout: got %0d cycles without completion expected <= 60", since);
          since = 0;
        end
      end
    end
  end

endmodule
